// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal arithmetic datapath (BCD adder/subtractor).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [3:0] BCD_MAX            = 4'd9;
  localparam logic [4:0] BCD_RADIX          = 5'd10;
  localparam int         BCD_DIGITS_DEFAULT = 4;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single decimal digit subtract stage: digit = a_i - b_i - borrow_in, wrapped into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic signed [4:0] t;
  logic        [4:0] t_adj;

  always_comb begin
    t          = $signed({1'b0, a_i}) - $signed({1'b0, b_i}) - $signed({4'd0, borrow_in});
    t_adj      = t + BCD_RADIX;
    borrow_out = t[4];
    digit      = borrow_out ? t_adj[3:0] : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor computing a - b - bin, least significant digit first.
// Optional operand validity check is built when BCD_SUB_INVALID_CHECK_EN is defined.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic [3:0]     dig;
  logic           bo;
  logic           last;
  logic           accept;
  logic           inv_pend;

  bcd_digit_sub u_digit (
    .a_i       (a_sh[3:0]),
    .b_i       (b_sh[3:0]),
    .borrow_in (borrow),
    .digit     (dig),
    .borrow_out(bo)
  );

  assign accept   = (state == IDLE) && start;
  assign last     = (cnt == CW'(DIGITS - 1));
  assign acc_next = W'({dig, acc} >> 4);

  // Operand/result shift registers: data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == CALC) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      acc  <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            borrow <= bin;
          end
        end
        CALC: begin
          cnt    <= cnt + 1'b1;
          borrow <= bo;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= inv_pend ? '0 : acc_next;
            bout  <= inv_pend ? 1'b0 : bo;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_SUB_INVALID_CHECK_EN
  function automatic logic has_non_bcd(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  // Flag is captured with the operands and published alongside the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_pend <= 1'b0;
      invalid  <= 1'b0;
    end else if (accept) begin
      inv_pend <= has_non_bcd(a) | has_non_bcd(b);
    end else if (state == CALC && last) begin
      invalid  <= inv_pend;
    end
  end
`else
  assign inv_pend = 1'b0;
  assign invalid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor against a decimal integer model.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, invalid;
  logic [W-1:0] diff;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         inv;
    bit           chk_data;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] x);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    int   r;
    r = bcd2int(x) - bcd2int(y) - int'(bi);
    e.bout = (r < 0);
    if (r < 0) r += 10 ** DIGITS;
    e.diff     = int2bcd(r);
    e.inv      = 1'b0;
    e.chk_data = 1'b1;
    e.cyc      = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        chk("invalid", {31'd0, invalid}, {31'd0, e.inv});
        if (e.chk_data) begin
          chk("diff", {16'd0, diff}, {16'd0, e.diff});
          chk("bout", {31'd0, bout}, {31'd0, e.bout});
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    e = model(x, y, bi);
    e.cyc = cyc + 1 + DIGITS;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   t0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_invalid", {31'd0, invalid}, 32'd0);
    reset = 1'b0;

    issue(16'h4321, 16'h1234, 1'b0);
    issue(16'h0000, 16'h0001, 1'b0);
    issue(16'h5000, 16'h0000, 1'b1);
    issue(16'h9999, 16'h9999, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1);
    issue(16'h9999, 16'h0000, 1'b0);

    for (int i = 0; i < 200; i++) issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));

    // start during CALC with different operands must be ignored
    @(negedge clk);
    a = 16'h7777; b = 16'h2222; bin = 1'b0; start = 1'b1;
    e = model(16'h7777, 16'h2222, 1'b0);
    e.cyc = cyc + 1 + DIGITS;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h9999; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);

    // start held high: back-to-back operations at full throughput
    @(negedge clk);
    a = 16'h1000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    t0 = cyc;
    e = model(16'h1000, 16'h0001, 1'b0);
    e.cyc = t0 + 1 + DIGITS;
    sb.push_back(e);
    e.cyc = t0 + 1 + (DIGITS + 2) + DIGITS;
    sb.push_back(e);
    repeat (DIGITS + 3) @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);

    // reset in the second CALC cycle discards the operation
    @(negedge clk);
    a = 16'h8642; b = 16'h1357; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("calc_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_diff", {16'd0, diff}, 32'd0);
    chk("midrst_bout", {31'd0, bout}, 32'd0);
    chk("midrst_invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DIGITS + 2) @(negedge clk);
    issue(16'h2468, 16'h1357, 1'b1);

    // operand with a non-BCD nibble
    @(negedge clk);
    a = 16'h00A0; b = 16'h0001; bin = 1'b0; start = 1'b1;
`ifdef BCD_SUB_INVALID_CHECK_EN
    e.diff = '0; e.bout = 1'b0; e.inv = 1'b1; e.chk_data = 1'b1;
`else
    e.diff = '0; e.bout = 1'b0; e.inv = 1'b0; e.chk_data = 1'b0;
`endif
    e.cyc = cyc + 1 + DIGITS;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 1) @(negedge clk);
    issue(16'h0500, 16'h0499, 1'b0);

    t0 = 0;
    while (sb.size() != 0 && t0 < 100) begin
      @(negedge clk);
      t0++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
